// File: rtl/shift_left_iter_if.sv
// Request/response bundle for the iterative left shifter: operands in,
// shifted result out, each side with its own valid/ready handshake.
interface shift_left_iter_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [DEPTH-1:0] b;
    logic             c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;

    modport master (
        output in_valid, a, b, c, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, a, b, c, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/shift_left_iter.sv
// Multi-cycle fill left shifter: out = (a << b) with vacated LSBs set to c,
// resolving one bit of b per cycle through a single shared shift stage.
module shift_left_iter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    shift_left_iter_if.slave bus
);
    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [DEPTH-1:0] amt_reg;
    logic             fill_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_reg;

    logic [DEPTH:0]   sh;
    logic [WIDTH-1:0] fill_mask;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] acc_next;
    logic             last_stage;

    // Stage distance is 2^cnt; distances >= WIDTH clear acc and fill every bit.
    assign sh = (DEPTH+1)'(1) << cnt_reg;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
            assign fill_mask[gi] = (32'(sh) > gi);
        end
    endgenerate

    assign shifted    = (acc_reg << sh) | (fill_mask & {WIDTH{fill_reg}});
    assign acc_next   = amt_reg[cnt_reg] ? shifted : acc_reg;
    assign last_stage = (cnt_reg == CNT_W'(DEPTH - 1));

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = out_valid_reg;
    assign bus.out       = out_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            amt_reg       <= '0;
            fill_reg      <= 1'b0;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_reg       <= '0;
        end else if (flush) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            out_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        acc_reg   <= bus.a;
                        amt_reg   <= bus.b;
                        fill_reg  <= bus.c;
                        cnt_reg   <= '0;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_reg <= acc_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    // Result is published straight from the final stage so
                    // out only ever carries a finished value.
                    if (last_stage) begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                        out_reg       <= acc_next;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        out_reg       <= '0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    out_reg       <= '0;
                end
            endcase
        end
    end
endmodule
